// File: rtl/wb_arbiter.sv
// wb_arbiter: merges single-cycle ALU results and buffered mult/div (MDU)
// results into one registered register-file write stream. It also keeps a
// pending-destination scoreboard so the issue stage can stall on RAW hazards
// against in-flight MDU operations.
module wb_arbiter #(
  parameter int DEPTH = 4,   // MDU result FIFO entries (power of 2, 2..16)
  parameter int AW    = 5,   // register address width
  parameter int DW    = 32   // data width
) (
  input  logic          clk_i,
  input  logic          rst_i,        // synchronous, active-low

  // ALU result path (always accepted)
  input  logic          alu_valid_i,
  input  logic [AW-1:0] alu_rd_i,
  input  logic [DW-1:0] alu_data_i,

  // MDU result path (valid/ready handshake into the FIFO)
  input  logic          mdu_valid_i,
  output logic          mdu_ready_o,
  input  logic [AW-1:0] mdu_rd_i,
  input  logic [DW-1:0] mdu_data_i,

  // Scoreboard set port and queries
  input  logic          issue_i,
  input  logic [AW-1:0] issue_rd_i,
  input  logic [AW-1:0] rs_addr_i,
  input  logic [AW-1:0] rt_addr_i,
  output logic          rs_busy_o,
  output logic          rt_busy_o,

  // Register-file write port
  output logic          RegWrite_o,
  output logic [AW-1:0] RDaddr_o,
  output logic [DW-1:0] RDdata_o
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << AW;

  // Elaboration-time guard on the FIFO geometry.
  if ((DEPTH < 2) || (DEPTH > 16) || ((1 << PW) != DEPTH)) begin : g_bad_depth
    $error("wb_arbiter: DEPTH must be a power of 2 in 2..16");
  end

  // ---------------------------------------------------------------------------
  // MDU result FIFO
  // ---------------------------------------------------------------------------
  logic [AW-1:0] fifo_rd   [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [AW-1:0] head_rd;
  logic [DW-1:0] head_data;

  // Ready comes from the registered count only: a full FIFO refuses a push
  // even in a cycle where it also pops. Held low while reset is asserted.
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign mdu_ready_o = rst_i && !full;
  assign push        = mdu_valid_i && mdu_ready_o;

  // The ALU always wins; the FIFO head drains only in ALU bubbles.
  assign pop         = rst_i && !alu_valid_i && !empty;

  assign head_rd     = fifo_rd[rd_ptr_q];
  assign head_data   = fifo_data[rd_ptr_q];

  // FIFO storage: written at the tail on an accepted push.
  // NOTE: the storage array has no reset; validity is tracked entirely by the
  // pointers and count, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd[wr_ptr_q]   <= mdu_rd_i;
      fifo_data[wr_ptr_q] <= mdu_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-destination scoreboard
  // ---------------------------------------------------------------------------
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Next pending vector: drain clears, issue sets; set is applied last so a
  // newer in-flight op to the same register keeps the bit. r0 is never busy.
  // NOTE: pending_d gets a full default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    pending_d = pending_q;
    if (pop) begin
      pending_d[head_rd] = 1'b0;
    end
    if (issue_i && (issue_rd_i != '0)) begin
      pending_d[issue_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Busy lookups see only the registered vector, never same-cycle updates.
  assign rs_busy_o = pending_q[rs_addr_i];
  assign rt_busy_o = pending_q[rt_addr_i];

  // ---------------------------------------------------------------------------
  // Registered write port
  // ---------------------------------------------------------------------------
  // Select ALU first, else the FIFO head; an r0 destination still consumes
  // the beat but suppresses the write enable. Address/data hold when idle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      RegWrite_o <= 1'b0;
      RDaddr_o   <= '0;
      RDdata_o   <= '0;
    end else if (alu_valid_i) begin
      RegWrite_o <= (alu_rd_i != '0);
      RDaddr_o   <= alu_rd_i;
      RDdata_o   <= alu_data_i;
    end else if (pop) begin
      RegWrite_o <= (head_rd != '0);
      RDaddr_o   <= head_rd;
      RDdata_o   <= head_data;
    end else begin
      RegWrite_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scenario tasks drive wb_arbiter one cycle at a time; a
// behavioural model predicts each cycle's write, pushes it to a scoreboard
// queue, and the entry is popped and compared once the DUT output settles.
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct {
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } mdu_t;

  logic          clk_i;
  logic          rst_i;
  logic          alu_valid_i;
  logic [AW-1:0] alu_rd_i;
  logic [DW-1:0] alu_data_i;
  logic          mdu_valid_i;
  logic          mdu_ready_o;
  logic [AW-1:0] mdu_rd_i;
  logic [DW-1:0] mdu_data_i;
  logic          issue_i;
  logic [AW-1:0] issue_rd_i;
  logic [AW-1:0] rs_addr_i;
  logic [AW-1:0] rt_addr_i;
  logic          rs_busy_o;
  logic          rt_busy_o;
  logic          RegWrite_o;
  logic [AW-1:0] RDaddr_o;
  logic [DW-1:0] RDdata_o;

  wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .alu_valid_i (alu_valid_i),
    .alu_rd_i    (alu_rd_i),
    .alu_data_i  (alu_data_i),
    .mdu_valid_i (mdu_valid_i),
    .mdu_ready_o (mdu_ready_o),
    .mdu_rd_i    (mdu_rd_i),
    .mdu_data_i  (mdu_data_i),
    .issue_i     (issue_i),
    .issue_rd_i  (issue_rd_i),
    .rs_addr_i   (rs_addr_i),
    .rt_addr_i   (rt_addr_i),
    .rs_busy_o   (rs_busy_o),
    .rt_busy_o   (rt_busy_o),
    .RegWrite_o  (RegWrite_o),
    .RDaddr_o    (RDaddr_o),
    .RDdata_o    (RDdata_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int        total  = 0;
  int        passed = 0;
  exp_t      exp_q[$];
  mdu_t      mfifo[$];
  logic [31:0] pend = '0;

  task automatic set_idle();
    alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
    mdu_valid_i = 1'b0; mdu_rd_i = '0; mdu_data_i = '0;
    issue_i     = 1'b0; issue_rd_i = '0;
  endtask

  // One clock: check combinational outputs, predict the edge, compare after it.
  task automatic tick();
    exp_t e;
    mdu_t m;
    logic ready_m, push_m, pop_m;
    #1;
    ready_m = rst_i && (mfifo.size() < DEPTH);
    total++;
    if (mdu_ready_o !== ready_m)
      $display("FAIL mdu_ready: got %b want %b at %0t", mdu_ready_o, ready_m, $time);
    else passed++;
    // pending is unknown before the first reset edge, so busy is checked only
    // once reset is released.
    if (rst_i) begin
      total++;
      if (rs_busy_o !== pend[rs_addr_i])
        $display("FAIL rs_busy[%0d]: got %b want %b at %0t", rs_addr_i, rs_busy_o, pend[rs_addr_i], $time);
      else passed++;
      total++;
      if (rt_busy_o !== pend[rt_addr_i])
        $display("FAIL rt_busy[%0d]: got %b want %b at %0t", rt_addr_i, rt_busy_o, pend[rt_addr_i], $time);
      else passed++;
    end
    push_m = mdu_valid_i && ready_m;
    pop_m  = rst_i && !alu_valid_i && (mfifo.size() > 0);
    e = '{we: 1'b0, rd: '0, data: '0};
    if (!rst_i) begin
      mfifo.delete();
      pend = '0;
    end else begin
      if (alu_valid_i) begin
        e = '{we: (alu_rd_i != 0), rd: alu_rd_i, data: alu_data_i};
      end else if (pop_m) begin
        m = mfifo.pop_front();
        e = '{we: (m.rd != 0), rd: m.rd, data: m.data};
        pend[m.rd] = 1'b0;
      end
      if (push_m) mfifo.push_back('{rd: mdu_rd_i, data: mdu_data_i});
      if (issue_i && issue_rd_i != 0) pend[issue_rd_i] = 1'b1;
      pend[0] = 1'b0;
    end
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    total++;
    if (RegWrite_o !== e.we)
      $display("FAIL regwrite: got %b want %b at %0t", RegWrite_o, e.we, $time);
    else passed++;
    if (e.we) begin
      total++;
      if (RDaddr_o !== e.rd || RDdata_o !== e.data)
        $display("FAIL write: got r%0d=%h want r%0d=%h at %0t", RDaddr_o, RDdata_o, e.rd, e.data, $time);
      else passed++;
    end
  endtask

  task automatic test_reset();
    set_idle();
    rst_i = 1'b0; rs_addr_i = 5'd5; rt_addr_i = 5'd0;
    tick();
    tick();
    total++;
    if (RDaddr_o !== '0 || RDdata_o !== '0)
      $display("FAIL reset_outputs: got r%0d=%h want r0=0", RDaddr_o, RDdata_o);
    else passed++;
    rst_i = 1'b1;
    alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'h0000_00AA;
    tick();
    set_idle();
    tick();
    total++;
    if (RDaddr_o !== 5'd5 || RDdata_o !== 32'hAA)
      $display("FAIL idle_hold: got r%0d=%h want r5=000000aa", RDaddr_o, RDdata_o);
    else passed++;
  endtask

  task automatic test_mdu_latency();
    set_idle();
    rs_addr_i = 5'd9; rt_addr_i = 5'd1;
    issue_i = 1'b1; issue_rd_i = 5'd9;
    tick();
    set_idle();
    tick();
    mdu_valid_i = 1'b1; mdu_rd_i = 5'd9; mdu_data_i = 32'h1234_5678;
    tick();                 // edge N: push
    set_idle();
    tick();                 // edge N+1: pop registered
    tick();                 // busy for r9 checked as 0 here
  endtask

  task automatic test_arbitration();
    set_idle();
    alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'd1;
    mdu_valid_i = 1'b1; mdu_rd_i = 5'd3; mdu_data_i = 32'h33;
    tick();
    alu_data_i = 32'd2; mdu_rd_i = 5'd4; mdu_data_i = 32'h44;
    tick();
    mdu_valid_i = 1'b0;
    alu_data_i = 32'd3;
    tick();
    set_idle();
    repeat (3) tick();
  endtask

  task automatic test_full();
    set_idle();
    alu_valid_i = 1'b1; alu_rd_i = 5'd8;
    for (int i = 0; i < DEPTH; i++) begin
      alu_data_i  = 32'(i);
      mdu_valid_i = 1'b1; mdu_rd_i = 5'(10 + i); mdu_data_i = 32'hA000_0000 + 32'(i);
      tick();
    end
    total++;
    if (mdu_ready_o !== 1'b0)
      $display("FAIL full_ready: got %b want 0", mdu_ready_o);
    else passed++;
    mdu_rd_i = 5'd14; mdu_data_i = 32'hA000_0004;
    tick();                 // offered while full: refused
    alu_valid_i = 1'b0;
    tick();                 // first pop; ready still low this cycle
    tick();                 // ready back; 5th beat accepted
    set_idle();
    repeat (6) tick();
  endtask

  task automatic test_r0_collision();
    set_idle();
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'hFFFF_FFFF;
    tick();
    set_idle();
    rs_addr_i = 5'd6; rt_addr_i = 5'd0;
    issue_i = 1'b1; issue_rd_i = 5'd6;
    tick();
    set_idle();
    mdu_valid_i = 1'b1; mdu_rd_i = 5'd6; mdu_data_i = 32'h6666;
    tick();
    set_idle();
    issue_i = 1'b1; issue_rd_i = 5'd6;   // same cycle as the r6 drain
    tick();
    set_idle();
    #1;
    total++;
    if (rs_busy_o !== 1'b1)
      $display("FAIL collision_busy: got %b want 1", rs_busy_o);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      issue_i = 1'b1; issue_rd_i = 5'(20 + i);
      tick();
    end
    set_idle();
    alu_valid_i = 1'b1; alu_rd_i = 5'd2;
    for (int i = 0; i < 3; i++) begin
      alu_data_i  = 32'(i);
      mdu_valid_i = 1'b1; mdu_rd_i = 5'(20 + i); mdu_data_i = 32'hB0 + 32'(i);
      tick();
    end
    set_idle();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 32; i++) begin
      rs_addr_i = 5'(i); rt_addr_i = 5'(31 - i);
      #1;
      total++;
      if (rs_busy_o !== 1'b0 || rt_busy_o !== 1'b0)
        $display("FAIL post_reset_busy[%0d]: got %b/%b want 0/0", i, rs_busy_o, rt_busy_o);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      alu_valid_i = ($urandom_range(0, 2) == 0);
      alu_rd_i    = 5'($urandom_range(0, 31));
      alu_data_i  = $urandom;
      mdu_valid_i = ($urandom_range(0, 1) == 1);
      mdu_rd_i    = 5'($urandom_range(0, 31));
      mdu_data_i  = $urandom;
      issue_i     = ($urandom_range(0, 2) == 0);
      issue_rd_i  = 5'($urandom_range(0, 31));
      rs_addr_i   = 5'($urandom_range(0, 31));
      rt_addr_i   = 5'($urandom_range(0, 31));
      tick();
    end
    set_idle();
    repeat (DEPTH + 2) tick();
  endtask

  initial begin
    rst_i = 1'b0;
    rs_addr_i = '0;
    rt_addr_i = '0;
    set_idle();
    test_reset();
    test_mdu_latency();
    test_arbitration();
    test_full();
    test_r0_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
